adc_reader: RTL and testbench
=============================

ADC_READER -- requirements
Module: adc_reader

Interface
REQ-001 Parameter DATA_BITS, 16, bits shifted per channel per conversion.
REQ-002 Parameter CNV_LOW, 4, CLK cycles CNVST_ADC is held low.
REQ-003 Parameter SCLK_DIV, 4, CLK cycles per SCLK_ADC half-period (minimum 2).
REQ-004 Parameter BUSY_TIMEOUT, 255, CLK cycles allowed in each BUSY wait state.
REQ-005 CLK  in  1  sole clock, all logic on rising edge.
REQ-006 RST  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  one-cycle request to run one conversion and readout.
REQ-008 CNVST_ADC  out  1  convert-start, active-low.
REQ-009 CS_ADC  out  1  serial chip select, active-low.
REQ-010 SCLK_ADC  out  1  serial clock, idles high.
REQ-011 BUSY_ADC  in  1  ADC conversion-busy, asynchronous to CLK.
REQ-012 DOUTA_ADC, DOUTB_ADC  in  1 each  serial data for channels A and B, MSB first.
REQ-013 data_a, data_b  out  DATA_BITS each  last captured results, held until the next valid.
REQ-014 valid  out  1  one-cycle pulse when data_a/data_b are updated.
REQ-015 busy  out  1  high whenever the FSM is not in IDLE.
REQ-016 err  out  1  one-cycle pulse on BUSY timeout.

Function
REQ-017 BUSY_ADC shall pass through a 2-flop synchronizer; the FSM shall use only the synchronized value.
REQ-018 States shall be IDLE, CONV, WAIT_HI, WAIT_LO, SHIFT, DONE.
REQ-019 IDLE: start=1 -> CONV, registering CNVST_ADC=0 on the same edge; start is ignored in all other states.
REQ-020 CONV: CNVST_ADC low for exactly CNV_LOW cycles, then high -> WAIT_HI.
REQ-021 WAIT_HI: synchronized BUSY=1 -> WAIT_LO; BUSY_TIMEOUT cycles without BUSY=1 -> IDLE with err pulse.
REQ-022 WAIT_LO: synchronized BUSY=0 -> SHIFT, registering CS_ADC=0 on the same edge; timeout -> IDLE with err pulse.
REQ-023 If BUSY is already high on WAIT_HI entry, WAIT_HI shall exit after one cycle.
REQ-024 SHIFT: DATA_BITS periods, each SCLK_ADC low for SCLK_DIV cycles, then high for SCLK_DIV cycles.
REQ-025 SHIFT: DOUTA_ADC/DOUTB_ADC shall be sampled on the CLK edge that drives SCLK_ADC high and shifted in MSB first.
REQ-026 After the last high phase, CS_ADC shall return to 1 and the FSM -> DONE.
REQ-027 DONE: data_a/data_b shall load the shift registers, valid shall pulse for 1 cycle, then -> IDLE.
REQ-028 Minimum start-to-valid latency shall be CNV_LOW + 2-cycle sync + BUSY high time + 2*SCLK_DIV*DATA_BITS + 2 cycles.
REQ-029 SCLK_ADC shall be high whenever CS_ADC is high.
REQ-030 Timeout counter shall reset on every state entry, saturate at BUSY_TIMEOUT, and shall not wrap.
REQ-031 data_a/data_b shall remain unchanged on an err abort.

Reset
REQ-032 RST=1 shall immediately force IDLE, CNVST_ADC=1, CS_ADC=1, SCLK_ADC=1, data_a=data_b=0, valid=0, busy=0, err=0, and clear all counters and synchronizers.
REQ-033 RST asserted mid-SHIFT shall abort with no valid pulse; after release the block shall accept a new start normally.

Verification
REQ-034 Single start, ADC model (BUSY rises 40 ns after CNVST fall, high 720 ns), DOUTA fixed pattern 0xA5C3, DOUTB 0x3C5A -> exactly one valid pulse with data_a=0xA5C3, data_b=0x3C5A, 16 SCLK rising edges, CS low throughout.
REQ-035 BUSY held low -> err pulse exactly BUSY_TIMEOUT cycles after WAIT_HI entry, busy=0 afterwards, no valid, data unchanged.
REQ-036 BUSY stuck high -> err pulse from WAIT_LO, CS_ADC never asserted.
REQ-037 Second start issued during SHIFT -> ignored; one valid only; an immediate start after valid -> second conversion runs.
REQ-038 RST pulsed halfway through SHIFT -> all outputs at reset values within the same cycle, no valid; a subsequent start completes correctly.
REQ-039 Check CNVST low width = CNV_LOW cycles and SCLK half-period = SCLK_DIV cycles for SCLK_DIV=2 and 4.

Source files
------------

// File: rtl/adc_reader.sv
// Dual-channel serial ADC sequencer: pulses convert-start, waits out BUSY, clocks DATA_BITS out of both channels.
// Results appear DATA_BITS*2*SCLK_DIV + handshake cycles after start; start is ignored while busy.
module adc_reader #(
  parameter int DATA_BITS    = 16,
  parameter int CNV_LOW      = 4,
  parameter int SCLK_DIV     = 4,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  output logic                 CNVST_ADC,
  output logic                 CS_ADC,
  output logic                 SCLK_ADC,
  input  logic                 BUSY_ADC,
  input  logic                 DOUTA_ADC,
  input  logic                 DOUTB_ADC,
  output logic [DATA_BITS-1:0] data_a,
  output logic [DATA_BITS-1:0] data_b,
  output logic                 valid,
  output logic                 busy,
  output logic                 err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CONV    = 3'd1;
  localparam logic [2:0] S_WAIT_HI = 3'd2;
  localparam logic [2:0] S_WAIT_LO = 3'd3;
  localparam logic [2:0] S_SHIFT   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam int PH_MAX = (CNV_LOW > SCLK_DIV) ? CNV_LOW : SCLK_DIV;
  localparam int PW     = $clog2(PH_MAX + 1);
  localparam int TW     = $clog2(BUSY_TIMEOUT + 1);
  localparam int BW     = $clog2(DATA_BITS + 1);

  localparam logic [PW-1:0] CNV_LAST  = PW'(CNV_LOW - 1);
  localparam logic [PW-1:0] HALF_LAST = PW'(SCLK_DIV - 1);
  localparam logic [PW-1:0] PH_ONE    = PW'(1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(BUSY_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE   = TW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);

  logic [2:0]           state;
  logic [PW-1:0]        ph_cnt;
  logic [TW-1:0]        tmo_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] sr_a;
  logic [DATA_BITS-1:0] sr_b;
  logic                 busy_meta;
  logic                 busy_sync;

  assign busy = (state != S_IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      CNVST_ADC <= 1'b1;
      CS_ADC    <= 1'b1;
      SCLK_ADC  <= 1'b1;
      ph_cnt    <= '0;
      tmo_cnt   <= '0;
      bit_cnt   <= '0;
      sr_a      <= '0;
      sr_b      <= '0;
      data_a    <= '0;
      data_b    <= '0;
      valid     <= 1'b0;
      err       <= 1'b0;
      busy_meta <= 1'b0;
      busy_sync <= 1'b0;
    end else begin
      busy_meta <= BUSY_ADC;
      busy_sync <= busy_meta;
      valid     <= 1'b0;
      err       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_CONV;
            CNVST_ADC <= 1'b0;
            ph_cnt    <= '0;
          end
        end
        S_CONV: begin
          if (ph_cnt == CNV_LAST) begin
            CNVST_ADC <= 1'b1;
            state     <= S_WAIT_HI;
            tmo_cnt   <= '0;
          end else begin
            ph_cnt <= ph_cnt + PH_ONE;
          end
        end
        S_WAIT_HI: begin
          if (busy_sync) begin
            state   <= S_WAIT_LO;
            tmo_cnt <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            state <= S_IDLE;
            err   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
        end
        S_WAIT_LO: begin
          if (!busy_sync) begin
            state    <= S_SHIFT;
            CS_ADC   <= 1'b0;
            SCLK_ADC <= 1'b0;
            ph_cnt   <= '0;
            bit_cnt  <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            state <= S_IDLE;
            err   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
        end
        S_SHIFT: begin
          // Data is captured on the edge that raises SCLK; the ADC updates DOUT while SCLK is low.
          if (ph_cnt != HALF_LAST) begin
            ph_cnt <= ph_cnt + PH_ONE;
          end else begin
            ph_cnt <= '0;
            if (!SCLK_ADC) begin
              SCLK_ADC <= 1'b1;
              sr_a     <= {sr_a[DATA_BITS-2:0], DOUTA_ADC};
              sr_b     <= {sr_b[DATA_BITS-2:0], DOUTB_ADC};
            end else if (bit_cnt == BIT_LAST) begin
              CS_ADC <= 1'b1;
              state  <= S_DONE;
            end else begin
              SCLK_ADC <= 1'b0;
              bit_cnt  <= bit_cnt + BIT_ONE;
            end
          end
        end
        S_DONE: begin
          data_a <= sr_a;
          data_b <= sr_b;
          valid  <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_reader.sv
// Directed bench for adc_reader: behavioural ADC model, SCLK/CNVST width monitors, immediate-assertion checks.
`timescale 1ns/1ps
module tb_adc_reader;

  localparam int BUDGET = 1000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic        CNVST_ADC, CS_ADC, SCLK_ADC;
  logic        BUSY_ADC = 1'b0;
  logic        DOUTA_ADC = 1'b0;
  logic        DOUTB_ADC = 1'b0;
  logic [15:0] data_a, data_b;
  logic        valid, busy, err;

  logic        start2 = 1'b0;
  logic        cnvst2, cs2, sclk2;
  logic        busy_adc2 = 1'b0;
  logic        douta2 = 1'b1;
  logic        doutb2 = 1'b0;
  logic [15:0] data_a2, data_b2;
  logic        valid2, busy2, err2;

  adc_reader dut (
    .CLK(CLK), .RST(RST), .start(start),
    .CNVST_ADC(CNVST_ADC), .CS_ADC(CS_ADC), .SCLK_ADC(SCLK_ADC),
    .BUSY_ADC(BUSY_ADC), .DOUTA_ADC(DOUTA_ADC), .DOUTB_ADC(DOUTB_ADC),
    .data_a(data_a), .data_b(data_b), .valid(valid), .busy(busy), .err(err)
  );

  adc_reader #(.SCLK_DIV(2)) dut2 (
    .CLK(CLK), .RST(RST), .start(start2),
    .CNVST_ADC(cnvst2), .CS_ADC(cs2), .SCLK_ADC(sclk2),
    .BUSY_ADC(busy_adc2), .DOUTA_ADC(douta2), .DOUTB_ADC(doutb2),
    .data_a(data_a2), .data_b(data_b2), .valid(valid2), .busy(busy2), .err(err2)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // ADC model state: busy_mode 0 = normal, 1 = stuck low, 2 = stuck high
  int          busy_mode = 0;
  logic [15:0] pat_a = 16'hA5C3;
  logic [15:0] pat_b = 16'h3C5A;
  int bk = -1, cnv_run = 0, cnv_w = 0, run = 0, lo_w = 0, hi_w = 0, sclk_bad = 0;
  int rises = 0, last_rises = 0, viol = 0, cs_falls = 0, valid_cnt = 0;
  logic cnv_prev = 1'b1, sclk_prev = 1'b1, cs_prev = 1'b1;
  int bk2 = -1, cnv_run2 = 0, cnv_w2 = 0, run2 = 0, lo_w2 = 0, hi_w2 = 0, sclk_bad2 = 0;
  logic cnv_prev2 = 1'b1, sclk_prev2 = 1'b1;

  // BUSY rises ~40 ns after CNVST falls and stays high for 720 ns (72 cycles)
  always @(negedge CLK) begin
    if (cnv_prev && !CNVST_ADC) bk = 0; else if (bk >= 0) bk++;
    BUSY_ADC = (busy_mode == 2) || (busy_mode == 0 && bk >= 4 && bk < 76);
    if (bk >= 76) bk = -1;
    cnv_prev = CNVST_ADC;
    if (!CNVST_ADC) cnv_run++;
    else if (cnv_run != 0) begin cnv_w = cnv_run; cnv_run = 0; end
    if (CS_ADC && !SCLK_ADC) viol++;
    if (cs_prev && !CS_ADC) cs_falls++;
    if (!CS_ADC) begin
      if (SCLK_ADC && !sclk_prev) rises++;
      if (SCLK_ADC == sclk_prev) run++;
      else begin
        if (run != 0) begin
          if (run != 4) sclk_bad++;
          if (sclk_prev) hi_w = run; else lo_w = run;
        end
        run = 1;
      end
    end else begin
      if (!cs_prev) last_rises = rises;
      rises = 0;
      run = 0;
    end
    DOUTA_ADC = (!CS_ADC && rises < 16) ? pat_a[4'(15 - rises)] : 1'b0;
    DOUTB_ADC = (!CS_ADC && rises < 16) ? pat_b[4'(15 - rises)] : 1'b0;
    sclk_prev = SCLK_ADC;
    cs_prev = CS_ADC;
    if (valid) valid_cnt++;
  end

  always @(negedge CLK) begin
    if (cnv_prev2 && !cnvst2) bk2 = 0; else if (bk2 >= 0) bk2++;
    busy_adc2 = (bk2 >= 4 && bk2 < 76);
    if (bk2 >= 76) bk2 = -1;
    cnv_prev2 = cnvst2;
    if (!cnvst2) cnv_run2++;
    else if (cnv_run2 != 0) begin cnv_w2 = cnv_run2; cnv_run2 = 0; end
    if (!cs2) begin
      if (sclk2 == sclk_prev2) run2++;
      else begin
        if (run2 != 0) begin
          if (run2 != 2) sclk_bad2++;
          if (sclk_prev2) hi_w2 = run2; else lo_w2 = run2;
        end
        run2 = 1;
      end
    end else begin
      run2 = 0;
    end
    sclk_prev2 = sclk2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic kick();
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(valid || err) && n < BUDGET) begin step(); n++; end
  endtask

  task automatic wait_cs_low();
    int n = 0;
    while (CS_ADC && n < BUDGET) begin step(); n++; end
  endtask

  int vc0, cf0;

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check("rst_cnvst", 32'(CNVST_ADC), 32'd1);
    check("rst_cs", 32'(CS_ADC), 32'd1);
    check("rst_sclk", 32'(SCLK_ADC), 32'd1);
    check("rst_data_a", 32'(data_a), 32'd0);
    check("rst_data_b", 32'(data_b), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) step();

    // Single conversion: 4 + 3 (sync+decide) + 72 + 128 + 1 = 208 cycles to valid
    kick();
    check("idle_busy_after_start", 32'(busy), 32'd1);
    wait_done();
    check("t1_latency", 32'(cyc), 32'd208);
    check("t1_data_a", 32'(data_a), 32'hA5C3);
    check("t1_data_b", 32'(data_b), 32'h3C5A);
    check("t1_sclk_rises", 32'(last_rises), 32'd16);
    check("t1_cnvst_width", 32'(cnv_w), 32'd4);
    check("t1_sclk_low", 32'(lo_w), 32'd4);
    check("t1_sclk_high", 32'(hi_w), 32'd4);
    check("t1_sclk_bad", 32'(sclk_bad), 32'd0);
    check("t1_sclk_low_cs_high", 32'(viol), 32'd0);
    step();
    check("t1_valid_pulse_1cyc", 32'(valid), 32'd0);
    check("t1_busy_idle", 32'(busy), 32'd0);
    check("t1_valid_count", 32'(valid_cnt), 32'd1);
    repeat (5) step();

    // Start during SHIFT is ignored; restart in the valid cycle is accepted
    vc0 = valid_cnt;
    kick();
    wait_cs_low();
    repeat (10) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done();
    check("t2_latency", 32'(cyc), 32'd208);
    check("t2_data_a", 32'(data_a), 32'hA5C3);
    pat_a = 16'h1234;
    pat_b = 16'hFEDC;
    kick();
    wait_done();
    check("t2_restart_latency", 32'(cyc), 32'd208);
    check("t2_restart_data_a", 32'(data_a), 32'h1234);
    check("t2_restart_data_b", 32'(data_b), 32'hFEDC);
    repeat (300) step();
    check("t2_valid_count", 32'(valid_cnt - vc0), 32'd2);

    // BUSY never rises: err BUSY_TIMEOUT cycles after WAIT_HI entry (edge 4)
    busy_mode = 1;
    vc0 = valid_cnt;
    kick();
    wait_done();
    check("t3_err_latency", 32'(cyc), 32'd259);
    check("t3_err", 32'(err), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_data_a_kept", 32'(data_a), 32'h1234);
    check("t3_data_b_kept", 32'(data_b), 32'hFEDC);
    step();
    check("t3_err_pulse_1cyc", 32'(err), 32'd0);
    check("t3_no_valid", 32'(valid_cnt - vc0), 32'd0);

    // BUSY stuck high: WAIT_HI exits after one cycle, WAIT_LO times out, CS stays high
    busy_mode = 2;
    repeat (5) step();
    cf0 = cs_falls;
    kick();
    wait_done();
    check("t4_err_latency", 32'(cyc), 32'd260);
    check("t4_err", 32'(err), 32'd1);
    check("t4_cs_never_low", 32'(cs_falls - cf0), 32'd0);
    busy_mode = 0;
    repeat (20) step();

    // Reset pulse halfway through SHIFT
    vc0 = valid_cnt;
    pat_a = 16'hA5C3;
    pat_b = 16'h3C5A;
    kick();
    wait_cs_low();
    repeat (64) step();
    #3;
    RST = 1'b1;
    #1;
    check("t5_rst_cnvst", 32'(CNVST_ADC), 32'd1);
    check("t5_rst_cs", 32'(CS_ADC), 32'd1);
    check("t5_rst_sclk", 32'(SCLK_ADC), 32'd1);
    check("t5_rst_data_a", 32'(data_a), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_valid", 32'(valid), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (20) step();
    check("t5_no_valid", 32'(valid_cnt - vc0), 32'd0);
    kick();
    wait_done();
    check("t5_restart_latency", 32'(cyc), 32'd208);
    check("t5_restart_data_a", 32'(data_a), 32'hA5C3);
    check("t5_restart_data_b", 32'(data_b), 32'h3C5A);

    // SCLK_DIV=2 instance: shift phase is 64 cycles
    start2 = 1'b1;
    @(posedge CLK);
    #1;
    start2 = 1'b0;
    cyc = 0;
    begin
      int n = 0;
      while (!(valid2 || err2) && n < BUDGET) begin step(); n++; end
    end
    check("d2_latency", 32'(cyc), 32'd144);
    check("d2_valid", 32'(valid2), 32'd1);
    check("d2_data_a", 32'(data_a2), 32'hFFFF);
    check("d2_data_b", 32'(data_b2), 32'h0000);
    check("d2_cnvst_width", 32'(cnv_w2), 32'd4);
    check("d2_sclk_low", 32'(lo_w2), 32'd2);
    check("d2_sclk_high", 32'(hi_w2), 32'd2);
    check("d2_sclk_bad", 32'(sclk_bad2), 32'd0);
    check("d2_busy_idle", 32'(busy2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
